// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column drive, 2-flop row synchronizer, scan classification and
// multi-scan press/release qualification. Define KEYPAD_AUTOREPEAT_EN to build auto-repeat.
module keypad_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned STABLE_SCANS  = 8,
    parameter int unsigned REPEAT_SCANS  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned PW = $clog2(STABLE_SCANS + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] STABLE_MAX  = PW'(STABLE_SCANS);

    typedef enum logic [1:0] {DRIVE, SAMPLE, EVAL} state_t;

    state_t          state_q, state_d;
    logic [3:0]      rs1_q, rs2_q;
    logic [1:0]      col_idx_q, col_idx_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [3:0][3:0] hits_q, hits_d;
    logic [3:0]      cand_q, cand_d;
    logic [PW-1:0]   press_cnt_q, press_cnt_d;
    logic [PW-1:0]   rel_cnt_q, rel_cnt_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic            key_down_q, key_down_d;
    logic [3:0]      col_drive;
    logic [15:0]     hits_flat;
    logic [4:0]      hit_count;
    logic [3:0]      hit_code;
    logic            scan_none, scan_single;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_SCANS + 1);
    localparam logic [RW-1:0] REPEAT_MAX = RW'(REPEAT_SCANS);
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
`else
    logic repeat_unused;
    assign repeat_unused = (REPEAT_SCANS == 0);
`endif

    // Hit bit index is row*4+col, so the index of a lone hit is its key code.
    assign hits_flat = hits_q;

    always_comb begin
        hit_count = '0;
        hit_code  = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (hits_flat[i]) begin
                hit_count = hit_count + 5'd1;
                hit_code  = 4'(i);
            end
        end
    end

    assign scan_none   = (hit_count == 5'd0);
    assign scan_single = (hit_count == 5'd1);

    always_comb begin
        col_drive = '1;
        if (state_q != EVAL) begin
            col_drive[col_idx_q] = 1'b0;
        end
    end

    // Reset gates the drive directly so the pins idle while reset is held.
    assign col_n     = reset ? 4'b1111 : col_drive;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        settle_d    = settle_q;
        hits_d      = hits_q;
        cand_d      = cand_q;
        press_cnt_d = press_cnt_q;
        rel_cnt_d   = rel_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_d   = rep_cnt_q;
`endif
        case (state_q)
            DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = SAMPLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            SAMPLE: begin
                for (int unsigned r = 0; r < 4; r++) begin
                    hits_d[r][col_idx_q] = ~rs2_q[r];
                end
                if (col_idx_q == 2'd3) begin
                    state_d = EVAL;
                end else begin
                    col_idx_d = col_idx_q + 2'd1;
                    state_d   = DRIVE;
                end
            end
            EVAL: begin
                col_idx_d = '0;
                state_d   = DRIVE;
                if (scan_single) begin
                    rel_cnt_d = '0;
                    // A zero press count means the stored candidate is stale.
                    if (press_cnt_q != '0 && hit_code == cand_q) begin
                        if (press_cnt_q != STABLE_MAX) begin
                            press_cnt_d = press_cnt_q + 1'b1;
                        end
                    end else begin
                        press_cnt_d = PW'(1);
                        cand_d      = hit_code;
                    end
                    if (press_cnt_d == STABLE_MAX && (cand_d != key_code_q || !key_down_q)) begin
                        key_code_d  = cand_d;
                        key_valid_d = 1'b1;
                        key_down_d  = 1'b1;
                    end
                end else if (scan_none) begin
                    press_cnt_d = '0;
                    if (rel_cnt_q != STABLE_MAX) begin
                        rel_cnt_d = rel_cnt_q + 1'b1;
                    end
                    if (rel_cnt_d == STABLE_MAX) begin
                        key_down_d = 1'b0;
                    end
                end else begin
                    press_cnt_d = '0;
                    rel_cnt_d   = '0;
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                if (scan_single && !key_valid_d && key_down_q && hit_code == key_code_q) begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                    if (rep_cnt_d == REPEAT_MAX) begin
                        rep_cnt_d   = '0;
                        key_valid_d = 1'b1;
                    end
                end else begin
                    rep_cnt_d = '0;
                end
`endif
            end
            default: state_d = DRIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= DRIVE;
            rs1_q       <= '1;
            rs2_q       <= '1;
            col_idx_q   <= '0;
            settle_q    <= '0;
            hits_q      <= '0;
            cand_q      <= '0;
            press_cnt_q <= '0;
            rel_cnt_q   <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rs1_q       <= row_n;
            rs2_q       <= rs1_q;
            col_idx_q   <= col_idx_d;
            settle_q    <= settle_d;
            hits_q      <= hits_d;
            cand_q      <= cand_d;
            press_cnt_q <= press_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: a keypad pin model plus a strobe scoreboard.
module tb_keypad_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] pressed = '0;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_strobe_cyc = -1;
    bit          prev_valid = 1'b0;
    logic [3:0]  exp_q[$];
    logic [3:0]  exp_code;

`ifdef KEYPAD_AUTOREPEAT_EN
    keypad_scan_ctrl #(.REPEAT_SCANS(4)) dut (
`else
    keypad_scan_ctrl dut (
`endif
        .clk(clk), .reset(reset), .row_n(row_n), .col_n(col_n),
        .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Pressed key at (row r, col c) shorts row r to column c.
    always_comb begin
        row_n = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            checks++;
            if (prev_valid) begin
                errors++;
                $display("FAIL valid_back_to_back got 1 exp 0 at cycle %0d", cyc);
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe got code %h exp no strobe at cycle %0d", key_code, cyc);
            end else begin
                exp_code = exp_q.pop_front();
                checks++;
                if (key_code !== exp_code) begin
                    errors++;
                    $display("FAIL strobe_code got %h exp %h", key_code, exp_code);
                end
                checks++;
                if (key_down !== 1'b1) begin
                    errors++;
                    $display("FAIL strobe_key_down got %b exp 1", key_down);
                end
            end
            last_strobe_cyc = cyc;
        end
        prev_valid = (key_valid === 1'b1);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int max_cycles, output bit drained);
        drained = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [3:0] exp_col;
        int pos;
        reset = 1'b1;
        pressed = '0;
        idle(3);
        checks++; if (col_n !== 4'b1111) begin errors++; $display("FAIL reset_col_n got %b exp 1111", col_n); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_key_code got %h exp 0", key_code); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid got %b exp 0", key_valid); end
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL reset_key_down got %b exp 0", key_down); end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 42; i++) begin
            pos = i % 21;
            exp_col = 4'b1111;
            if (pos < 20) exp_col[pos/5] = 1'b0;
            checks++;
            if (col_n !== exp_col) begin
                errors++;
                $display("FAIL col_walk cycle %0d got %b exp %b", i, col_n, exp_col);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_clean_press;
        bit d;
        int start;
        pressed = 16'h0040;
        exp_q.push_back(4'h6);
        start = cyc;
        wait_drain(400, d);
        checks++; if (!d) begin errors++; $display("FAIL clean_press_timeout got no strobe exp code 6"); end
        checks++;
        if (last_strobe_cyc - start < 156 || last_strobe_cyc - start > 176) begin
            errors++;
            $display("FAIL clean_press_latency got %0d exp 156..176", last_strobe_cyc - start);
        end
        if (cyc - start < 300) idle(300 - (cyc - start));
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL clean_press_down got %b exp 1", key_down); end
        checks++; if (key_code !== 4'h6) begin errors++; $display("FAIL clean_press_code got %h exp 6", key_code); end
    endtask

    task automatic test_release;
        pressed = '0;
        idle(100);
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL release_early_down got %b exp 1", key_down); end
        idle(130);
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL release_down got %b exp 0", key_down); end
        checks++; if (key_code !== 4'h6) begin errors++; $display("FAIL release_code got %h exp 6", key_code); end
    endtask

    task automatic test_bounce;
        bit d;
        pressed = 16'h0040;
        for (int k = 0; k < 14; k++) begin
            idle(15);
            pressed = pressed ^ 16'h0040;
        end
        pressed = 16'h0040;
        exp_q.push_back(4'h6);
        wait_drain(300, d);
        checks++; if (!d) begin errors++; $display("FAIL bounce_timeout got no strobe exp code 6"); end
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL bounce_down got %b exp 1", key_down); end
    endtask

    task automatic test_ghosting;
        pressed = 16'h0021;
        idle(300);
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL ghost_down got %b exp 0", key_down); end
        checks++; if (key_code !== 4'h6) begin errors++; $display("FAIL ghost_code got %h exp 6", key_code); end
        pressed = '0;
        idle(50);
    endtask

    task automatic test_reset_mid_scan;
        bit d;
        int start;
        pressed = 16'h0040;
        idle(107);
        reset = 1'b1;
        idle(2);
        checks++; if (col_n !== 4'b1111) begin errors++; $display("FAIL midreset_col_n got %b exp 1111", col_n); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL midreset_code got %h exp 0", key_code); end
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL midreset_down got %b exp 0", key_down); end
        reset = 1'b0;
        exp_q.push_back(4'h6);
        start = cyc;
        #1;
        checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL midreset_restart_col got %b exp 1110", col_n); end
        wait_drain(400, d);
        checks++; if (!d) begin errors++; $display("FAIL midreset_timeout got no strobe exp code 6"); end
        checks++;
        if (last_strobe_cyc - start != 168) begin
            errors++;
            $display("FAIL midreset_latency got %0d exp 168", last_strobe_cyc - start);
        end
    endtask

    task automatic test_rollover;
        bit dropped;
        bit d3;
        bit dc;
        dropped = 1'b0;
        d3 = 1'b0;
        dc = 1'b0;
        pressed = 16'h0008;
        exp_q.push_back(4'h3);
        for (int i = 0; i < 400 && !d3; i++) begin
            @(posedge clk); #1;
            if (key_down !== 1'b1) dropped = 1'b1;
            if (exp_q.size() == 0) d3 = 1'b1;
        end
        pressed = 16'h1000;
        exp_q.push_back(4'hC);
        for (int i = 0; i < 400 && !dc; i++) begin
            @(posedge clk); #1;
            if (key_down !== 1'b1) dropped = 1'b1;
            if (exp_q.size() == 0) dc = 1'b1;
        end
        checks++; if (!d3) begin errors++; $display("FAIL rollover_first_timeout got no strobe exp code 3"); end
        checks++; if (!dc) begin errors++; $display("FAIL rollover_second_timeout got no strobe exp code c"); end
        checks++; if (dropped) begin errors++; $display("FAIL rollover_down got dropped exp held 1"); end
        checks++; if (key_code !== 4'hC) begin errors++; $display("FAIL rollover_code got %h exp c", key_code); end
        idle(200);
    endtask

`ifdef KEYPAD_AUTOREPEAT_EN
    task automatic test_autorepeat;
        bit d;
        int t0;
        pressed = 16'h0200;
        exp_q.push_back(4'h9);
        wait_drain(400, d);
        checks++; if (!d) begin errors++; $display("FAIL repeat_first_timeout got no strobe exp code 9"); end
        for (int k = 0; k < 2; k++) begin
            t0 = last_strobe_cyc;
            exp_q.push_back(4'h9);
            wait_drain(200, d);
            checks++; if (!d) begin errors++; $display("FAIL repeat_timeout got no strobe exp code 9"); end
            checks++;
            if (last_strobe_cyc - t0 != 84) begin
                errors++;
                $display("FAIL repeat_interval got %0d exp 84", last_strobe_cyc - t0);
            end
        end
        pressed = '0;
        idle(300);
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL repeat_release_down got %b exp 0", key_down); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef KEYPAD_AUTOREPEAT_EN
        test_autorepeat();
`else
        test_clean_press();
        test_release();
        test_bounce();
        test_release();
        test_ghosting();
        test_reset_mid_scan();
        test_rollover();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_strobes got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
